// File: rtl/multiport_bram.sv
// rtl/multiport_bram.sv - multi-port byte-enable RAM with INIT clear and 1/2-cycle read pipeline
// Optional write-collision detection is built when BRAM_COLLISION_CHK_EN is defined.
module multiport_bram #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int NUM_PORTS  = 2,
  parameter int RD_LATENCY = 1,
  parameter int READ_MODE  = 0,
  localparam int AW        = $clog2(DEPTH),
  localparam int NB        = WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      ready,
  input  logic [NUM_PORTS-1:0]      en,
  input  logic [NUM_PORTS-1:0]      we,
  input  logic [NUM_PORTS*NB-1:0]   be,
  input  logic [NUM_PORTS*AW-1:0]   addr,
  input  logic [NUM_PORTS*WIDTH-1:0] din,
  output logic [NUM_PORTS*WIDTH-1:0] dout,
  output logic [NUM_PORTS-1:0]      dout_valid,
  output logic [NUM_PORTS-1:0]      collision
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             init_clr;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    addr_p [NUM_PORTS];
  logic [NB-1:0]    be_p   [NUM_PORTS];
  logic [WIDTH-1:0] din_p  [NUM_PORTS];
  logic [WIDTH-1:0] rd_d   [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_rng, acc, wr;

  logic [NUM_PORTS*WIDTH-1:0] dout1_q;
  logic [NUM_PORTS-1:0]       vld1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    init_clr = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_clr = 1'b1;
        cnt_d    = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  assign ready = (state_q == ST_RUN);

  // Write-first merges only this port's own bytes; other ports' same-cycle writes stay invisible.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      addr_p[p] = addr[p*AW +: AW];
      be_p[p]   = be[p*NB +: NB];
      din_p[p]  = din[p*WIDTH +: WIDTH];
      in_rng[p] = (int'(addr_p[p]) < DEPTH);
      acc[p]    = ready & en[p];
      wr[p]     = acc[p] & we[p] & in_rng[p];
      rd_d[p]   = in_rng[p] ? mem_q[addr_p[p]] : '0;
      if (READ_MODE == 1 && wr[p]) begin
        for (int b = 0; b < NB; b++) begin
          if (be_p[p][b]) rd_d[p][8*b +: 8] = din_p[p][8*b +: 8];
        end
      end
    end
  end

  // Ports are applied highest first so the lowest-indexed port's byte lands last and wins.
  always_ff @(posedge clk) begin
    if (init_clr) mem_q[cnt_q] <= '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (wr[p]) begin
        for (int b = 0; b < NB; b++) begin
          if (be_p[p][b]) mem_q[addr_p[p]][8*b +: 8] <= din_p[p][8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout1_q <= '0;
      vld1_q  <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        vld1_q[p]                  <= acc[p];
        dout1_q[p*WIDTH +: WIDTH]  <= acc[p] ? rd_d[p] : '0;
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [NUM_PORTS*WIDTH-1:0] dout2_q;
      logic [NUM_PORTS-1:0]       vld2_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          dout2_q <= '0;
          vld2_q  <= '0;
        end else begin
          dout2_q <= dout1_q;
          vld2_q  <= vld1_q;
        end
      end
      assign dout       = dout2_q;
      assign dout_valid = vld2_q;
    end else begin : g_lat1
      assign dout       = dout1_q;
      assign dout_valid = vld1_q;
    end
  endgenerate

`ifdef BRAM_COLLISION_CHK_EN
  logic [NUM_PORTS-1:0] coll_d, coll_q;

  always_comb begin
    coll_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = 0; j < i; j++) begin
        if (wr[i] && wr[j] && addr_p[i] == addr_p[j] && |(be_p[i] & be_p[j]))
          coll_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) coll_q <= '0;
    else        coll_q <= coll_d;
  end

  assign collision = coll_q;
`else
  assign collision = '0;
`endif

endmodule

// File: doc/multiport_bram.md
MULTIPORT_BRAM -- requirements
Module: multiport_bram

Interface
REQ-001 Parameter WIDTH, 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, 32, number of words; SHALL be >= 2 and need not be a power of 2.
REQ-003 Parameter NUM_PORTS, 2, number of independent read/write ports; SHALL be 1..4.
REQ-004 Parameter RD_LATENCY, 1, cycles from accepted read to dout_valid; SHALL be 1 or 2.
REQ-005 Parameter READ_MODE, 0, same-port read-during-write result: 0 = read-first, 1 = write-first.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 ready  output  1  high when init is complete and requests are accepted.
REQ-009 en  input  [NUM_PORTS] x 1  per-port access request.
REQ-010 we  input  [NUM_PORTS] x 1  per-port write qualifier; meaningful only with en.
REQ-011 be  input  [NUM_PORTS] x WIDTH/8  per-port byte enables for writes.
REQ-012 addr  input  [NUM_PORTS] x $clog2(DEPTH)  per-port word address.
REQ-013 din  input  [NUM_PORTS] x WIDTH  per-port write data.
REQ-014 dout  output  [NUM_PORTS] x WIDTH  per-port read data.
REQ-015 dout_valid  output  [NUM_PORTS] x 1  dout qualifier.
REQ-016 collision  output  [NUM_PORTS] x 1  write-collision pulse (see Configuration).

Function
REQ-017 Controller FSM SHALL have two states, INIT and RUN; INIT clears mem[cnt] to 0 and increments cnt each cycle, and moves to RUN after clearing address DEPTH-1 (DEPTH cycles total).
REQ-018 ready SHALL be 0 in INIT and 1 in RUN; en is ignored while ready=0 (no write, no dout_valid).
REQ-019 An access is accepted when ready=1 and en[i]=1; every accepted access, read or write, SHALL produce dout_valid[i]=1 exactly RD_LATENCY cycles later with dout[i] holding the data word.
REQ-020 RD_LATENCY=2 SHALL add one output register stage; dout_valid and dout stay aligned and the path is fully pipelined (one access per port per cycle).
REQ-021 Accepted write with we[i]=1 SHALL update only bytes with be[i] set; be=0 writes nothing.
REQ-022 Same-port read-during-write: READ_MODE=0 returns the pre-write word, READ_MODE=1 returns the merged post-write word.
REQ-023 Cross-port read of an address written in the same cycle SHALL return the pre-write word regardless of READ_MODE.
REQ-024 Same-cycle writes from several ports to one address: per byte, the lowest-indexed port with that byte enabled SHALL win.
REQ-025 addr >= DEPTH: writes SHALL be dropped; reads SHALL return 0 with dout_valid asserted normally.
REQ-026 dout and dout_valid SHALL be 0 whenever no valid data is presented.

Reset
REQ-027 reset low SHALL immediately force state=INIT, cnt=0, ready=0, dout=0, dout_valid=0 and collision=0, and flush the read pipeline.
REQ-028 Reset asserted mid-operation SHALL discard in-flight reads; after release, memory SHALL be fully re-cleared before ready rises.
REQ-029 First INIT write SHALL occur on the first rising edge after reset deasserts.

Configuration
REQ-030 Macro BRAM_COLLISION_CHK_EN defined: collision[i] SHALL pulse high for one cycle, one cycle after an accepted write on port i that lost at least one byte to a lower-indexed port under REQ-024.
REQ-031 Macro BRAM_COLLISION_CHK_EN undefined: the collision port SHALL remain present and be tied to 0, and no detection logic shall be built.

Verification (WIDTH=32, DEPTH=16, NUM_PORTS=2 unless stated)
REQ-032 Release reset, keep en=0 -> ready=0 for 16 cycles, then 1; read of each of addresses 0..15 returns 0x00000000.
REQ-033 Port0 writes 0xDEADBEEF to addr 3 with be=4'b0101, then reads addr 3 -> dout[0]=0x00AD00EF with dout_valid[0] RD_LATENCY cycles after the read, for RD_LATENCY=1 and 2.
REQ-034 Port0 and port1 write addr 5 in the same cycle (0x11111111 with be=4'b0011; 0x22222222 with be=4'b1111) -> mem[5]=0x22221111, and collision[1] pulses only with BRAM_COLLISION_CHK_EN defined.
REQ-035 mem[7]=0xA5A5A5A5, port0 writes 0x5A5A5A5A to addr 7 while reading it -> dout[0]=0xA5A5A5A5 with READ_MODE=0 and 0x5A5A5A5A with READ_MODE=1; a same-cycle port1 read of addr 7 returns 0xA5A5A5A5 in both modes.
REQ-036 Assert reset one cycle after a read with RD_LATENCY=2 -> no dout_valid; after release, ready stays 0 for 16 cycles and previously written data reads back as 0.
REQ-037 DEPTH=12, write addr 13 then read addr 13 -> memory is unchanged and dout=0 with dout_valid=1.
